// File: rtl/spi_flash_pkg.sv
// Shared opcodes, state encoding and address-phase length for the SPI flash command engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_flash_pkg;

  localparam int ADDR_BYTES = 3;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_flash_prefetch.sv
// Read-stream fetcher: memory request/ack handshake, 1-byte prefetch buffer, address increment.
// Latency: first byte is handed to the tx path in the ack cycle; later bytes come from the prefetch buffer on each take.
// Backpressure: the request is held until ack; a take with no prefetched byte reports an underrun (drop) and loads on arrival.
module spi_flash_prefetch #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              take,
  output logic              load,
  output logic [7:0]        load_data,
  output logic              drop,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  input  logic [7:0]        mem_rd_data
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        pf_q, pf_d;
  logic              pf_vld_q, pf_vld_d;
  logic              wait_q, wait_d;
  logic              underrun_q, underrun_d;
  logic              ack;

  // An ack only counts while a request is outstanding, so acks after an abort are dropped.
  assign ack        = mem_rd_ack & req_q;
  assign mem_rd_req = req_q;
  assign mem_addr   = addr_q;

  // Next-state: a request is outstanding only while the prefetch buffer is empty.
  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    pf_d       = pf_q;
    pf_vld_d   = pf_vld_q;
    wait_d     = wait_q;
    underrun_d = underrun_q;
    load       = 1'b0;
    load_data  = mem_rd_data;
    drop       = 1'b0;
    if (clear) begin
      req_d    = 1'b0;
      pf_vld_d = 1'b0;
      wait_d   = 1'b0;
    end else if (start) begin
      addr_d   = start_addr;
      req_d    = 1'b1;
      pf_vld_d = 1'b0;
      wait_d   = 1'b1;
    end else begin
      if (take && pf_vld_q) begin
        load      = 1'b1;
        load_data = pf_q;
        pf_vld_d  = 1'b0;
        req_d     = 1'b1;
      end else if (take && !ack) begin
        drop       = 1'b1;
        wait_d     = 1'b1;
        underrun_d = 1'b1;
      end
      if (ack) begin
        addr_d = addr_q + ADDR_W'(1);
        if (wait_q || take) begin
          load      = 1'b1;
          load_data = mem_rd_data;
          wait_d    = 1'b0;
          req_d     = 1'b1;
        end else begin
          pf_d     = mem_rd_data;
          pf_vld_d = 1'b1;
          req_d    = 1'b0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      addr_q     <= '0;
      pf_q       <= '0;
      pf_vld_q   <= 1'b0;
      wait_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      pf_q       <= pf_d;
      pf_vld_q   <= pf_vld_d;
      wait_q     <= wait_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: rtl/spi_flash_cmd_engine.sv
// Read-only SPI NOR command layer (READ, RDID, RDSR; FAST_READ when SPI_FLASH_FAST_READ_EN is defined).
// Latency: tx byte/strobe registered one cycle after the rx strobe or memory ack that produces it.
// Backpressure: none toward the shifter; memory request held until ack; cs high aborts everything next cycle.
module spi_flash_cmd_engine
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W     = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_rx_strobe,
  input  logic [7:0]        spi_rx_data,
  output logic              spi_tx_strobe,
  output logic [7:0]        spi_tx_data,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  input  logic [7:0]        mem_rd_data,
  output logic              busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] ashift_q, ashift_d;
  logic        tx_strobe_q, tx_strobe_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
`ifdef SPI_FLASH_FAST_READ_EN
  logic        fast_q, fast_d;
`endif

  logic [23:0]       addr_full;
  logic              pf_clear, pf_start, pf_take, pf_load, pf_drop;
  logic [7:0]        pf_load_data;
  logic [ADDR_W-1:0] pf_start_addr;

  // Address as it stands once the current rx byte is shifted in.
  assign addr_full = {ashift_q[15:0], spi_rx_data};

  // Decode FSM and tx mux; chip-select high overrides every state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ashift_d      = ashift_q;
    tx_strobe_d   = tx_strobe_q;
    tx_data_d     = tx_data_q;
    pf_clear      = 1'b0;
    pf_start      = 1'b0;
    pf_take       = 1'b0;
    pf_start_addr = (state_q == ST_ADDR) ? addr_full[ADDR_W-1:0] : ashift_q[ADDR_W-1:0];
`ifdef SPI_FLASH_FAST_READ_EN
    fast_d        = fast_q;
`endif
    if (spi_cs) begin
      state_d     = ST_IDLE;
      tx_strobe_d = 1'b0;
      pf_clear    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = 2'd0;
        end
        ST_CMD: begin
          if (spi_rx_strobe) begin
            cnt_d = 2'd0;
            case (spi_rx_data)
              OP_READ: begin
                state_d = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                fast_d  = 1'b0;
`endif
              end
`ifdef SPI_FLASH_FAST_READ_EN
              OP_FAST_READ: begin
                state_d = ST_ADDR;
                fast_d  = 1'b1;
              end
`endif
              OP_RDID: begin
                state_d     = ST_ID;
                tx_data_d   = JEDEC_ID[23:16];
                tx_strobe_d = 1'b1;
              end
              OP_RDSR: begin
                state_d     = ST_STAT;
                tx_data_d   = STATUS_VAL & 8'hFE;
                tx_strobe_d = 1'b1;
              end
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (spi_rx_strobe) begin
            ashift_d = addr_full;
            cnt_d    = cnt_q + 2'd1;
            if (cnt_q == 2'(ADDR_BYTES - 1)) begin
`ifdef SPI_FLASH_FAST_READ_EN
              if (fast_q) begin
                state_d = ST_DUMMY;
              end else begin
                state_d  = ST_DATA;
                pf_start = 1'b1;
              end
`else
              state_d  = ST_DATA;
              pf_start = 1'b1;
`endif
            end
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY: begin
          if (spi_rx_strobe) begin
            state_d  = ST_DATA;
            pf_start = 1'b1;
          end
        end
`endif
        ST_DATA: pf_take = spi_rx_strobe;
        ST_ID: begin
          if (spi_rx_strobe) begin
            if (cnt_q == 2'd0) begin
              tx_data_d = JEDEC_ID[15:8];
              cnt_d     = 2'd1;
            end else if (cnt_q == 2'd1) begin
              tx_data_d = JEDEC_ID[7:0];
              cnt_d     = 2'd2;
            end else begin
              tx_strobe_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (state_q == ST_DATA && pf_load) begin
        tx_data_d   = pf_load_data;
        tx_strobe_d = 1'b1;
      end else if (state_q == ST_DATA && pf_drop) begin
        tx_strobe_d = 1'b0;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      ashift_q    <= '0;
      tx_strobe_q <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ashift_q    <= ashift_d;
      tx_strobe_q <= tx_strobe_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q      <= fast_d;
`endif
    end
  end

  assign spi_tx_strobe = tx_strobe_q;
  assign spi_tx_data   = tx_data_q;
  assign busy          = busy_q;

  spi_flash_prefetch #(.ADDR_W(ADDR_W)) u_prefetch (
    .clk         (clk),
    .reset       (reset),
    .clear       (pf_clear),
    .start       (pf_start),
    .start_addr  (pf_start_addr),
    .take        (pf_take),
    .load        (pf_load),
    .load_data   (pf_load_data),
    .drop        (pf_drop),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// Scoreboard bench: each sent byte pushes the byte the flash must shift out in that slot; a monitor
// pops and compares on every rx strobe. A memory model acks requests with data = addr[7:0] and checks
// requested addresses against an expected-address queue.
module tb_spi_flash_cmd_engine;

  localparam int GAP     = 12;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs;
  logic        spi_rx_strobe;
  logic [7:0]  spi_rx_data;
  logic        spi_tx_strobe;
  logic [7:0]  spi_tx_data;
  logic        mem_rd_req;
  logic [23:0] mem_addr;
  logic        model_ack;
  logic        stray_ack;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic        busy;

  int tests     = 0;
  int fails     = 0;
  int req_count = 0;

  logic [7:0]  tx_q[$];
  logic [23:0] addr_q[$];

  assign mem_rd_ack = model_ack | stray_ack;

  always #5 clk = ~clk;

  spi_flash_cmd_engine #(
    .ADDR_W     (24),
    .JEDEC_ID   (24'hEF4018),
    .STATUS_VAL (8'h03)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_cs        (spi_cs),
    .spi_rx_strobe (spi_rx_strobe),
    .spi_rx_data   (spi_rx_data),
    .spi_tx_strobe (spi_tx_strobe),
    .spi_tx_data   (spi_tx_data),
    .mem_rd_req    (mem_rd_req),
    .mem_addr      (mem_addr),
    .mem_rd_ack    (mem_rd_ack),
    .mem_rd_data   (mem_rd_data),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Byte exchanged in a slot: tx data if strobe high, else the shifter's 0xFF filler.
  initial begin : tx_monitor
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (spi_rx_strobe) begin
        got = spi_tx_strobe ? spi_tx_data : 8'hFF;
        if (tx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got %0h with no byte expected", got);
        end else begin
          check("tx_byte", {24'h0, got}, {24'h0, tx_q.pop_front()});
        end
      end
    end
  end

  // Memory model: fixed latency, data = low address byte; trailing prefetch requests are not checked.
  initial begin : mem_model
    logic [23:0] a;
    model_ack   = 1'b0;
    mem_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rd_req) begin
        a = mem_addr;
        req_count++;
        if (addr_q.size() != 0) check("mem_addr", {8'h0, a}, {8'h0, addr_q.pop_front()});
        repeat (MEM_LAT) @(posedge clk);
        #1;
        model_ack   = 1'b1;
        mem_rd_data = a[7:0];
        @(posedge clk);
        #1;
        model_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] b, input logic [7:0] exp);
    tx_q.push_back(exp);
    spi_rx_data   = b;
    spi_rx_strobe = 1'b1;
    @(posedge clk); #1;
    spi_rx_strobe = 1'b0;
    repeat (GAP) begin @(posedge clk); #1; end
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic cs_end(input string name);
    spi_cs = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_txstb"}, {31'h0, spi_tx_strobe}, 32'h0);
    check({name, "_req"}, {31'h0, mem_rd_req}, 32'h0);
  endtask

  initial begin : stimulus
    int rc;
    reset         = 1'b1;
    spi_cs        = 1'b1;
    spi_rx_strobe = 1'b0;
    spi_rx_data   = 8'h00;
    stray_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txstb", {31'h0, spi_tx_strobe}, 32'h0);
    check("rst_txdat", {24'h0, spi_tx_data}, 32'h0);
    check("rst_req", {31'h0, mem_rd_req}, 32'h0);
    check("rst_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // RDID
    cs_begin();
    check("cs_busy", {31'h0, busy}, 32'h1);
    send(8'h9F, 8'hFF); send(8'h00, 8'hEF); send(8'h00, 8'h40); send(8'h00, 8'h18);
    check("rdid_end_stb", {31'h0, spi_tx_strobe}, 32'h0);
    send(8'h00, 8'hFF);
    cs_end("rdid");

    // READ 0x000100, four data slots
    for (int i = 0; i < 5; i++) addr_q.push_back(24'h000100 + 24'(i));
    cs_begin();
    send(8'h03, 8'hFF); send(8'h00, 8'hFF); send(8'h01, 8'hFF); send(8'h00, 8'hFF);
    send(8'h00, 8'h00); send(8'h00, 8'h01); send(8'h00, 8'h02); send(8'h00, 8'h03);
    check("read_addrs_seen", addr_q.size(), 32'h0);
    cs_end("read");

    // READ wrapping past the top of the address space
    addr_q.push_back(24'hFFFFFE); addr_q.push_back(24'hFFFFFF); addr_q.push_back(24'h000000);
    cs_begin();
    send(8'h03, 8'hFF); send(8'hFF, 8'hFF); send(8'hFF, 8'hFF); send(8'hFE, 8'hFF);
    send(8'h00, 8'hFE); send(8'h00, 8'hFF); send(8'h00, 8'h00);
    check("wrap_addrs_seen", addr_q.size(), 32'h0);
    cs_end("wrap");

    // RDSR with WIP forced clear
    cs_begin();
    send(8'h05, 8'hFF); send(8'h00, 8'h02); send(8'h00, 8'h02); send(8'h00, 8'h02);
    cs_end("rdsr");

    // Abort mid-address, stray ack during abort, then clean RDID
    rc = req_count;
    cs_begin();
    send(8'h03, 8'hFF); send(8'h12, 8'hFF); send(8'h34, 8'hFF);
    spi_cs    = 1'b1;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    cs_end("abort");
    cs_begin();
    send(8'h9F, 8'hFF); send(8'h00, 8'hEF); send(8'h00, 8'h40); send(8'h00, 8'h18);
    cs_end("abort_rdid");
    check("abort_no_req", req_count - rc, 32'h0);

    // Write opcode is ignored
    rc = req_count;
    cs_begin();
    send(8'h02, 8'hFF); send(8'h00, 8'hFF); send(8'h00, 8'hFF); send(8'h00, 8'hFF);
    cs_end("write_ign");
    check("write_no_req", req_count - rc, 32'h0);

    // FAST_READ 0x000010
`ifdef SPI_FLASH_FAST_READ_EN
    addr_q.push_back(24'h000010); addr_q.push_back(24'h000011);
    cs_begin();
    send(8'h0B, 8'hFF); send(8'h00, 8'hFF); send(8'h00, 8'hFF); send(8'h10, 8'hFF);
    send(8'h00, 8'hFF); send(8'h00, 8'h10); send(8'h00, 8'h11);
    check("fast_addrs_seen", addr_q.size(), 32'h0);
    cs_end("fast");
`else
    rc = req_count;
    cs_begin();
    send(8'h0B, 8'hFF); send(8'h00, 8'hFF); send(8'h00, 8'hFF); send(8'h10, 8'hFF);
    send(8'h00, 8'hFF); send(8'h00, 8'hFF); send(8'h00, 8'hFF);
    cs_end("fast_ign");
    check("fast_no_req", req_count - rc, 32'h0);
`endif

    check("tx_drained", tx_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_flash_cmd_engine.md
Name: spi_flash_cmd_engine

Overview:
- Command layer directly downstream of the SPI slave shifter in the SPI flash simulator.
- Consumes received bytes (rx strobe + data) and decodes the serial-flash command set.
- Fetches read data from an external byte-wide memory port.
- Feeds the shifter's transmit byte/strobe so the target sees a read-only SPI NOR flash.

Parameters:
- ADDR_W, 24, width of the flash byte address; the address phase is always 3 bytes, and upper unused bits are dropped.
- JEDEC_ID, 24'hEF4018, manufacturer/type/capacity returned by RDID, MSB byte first.
- STATUS_VAL, 8'h00, byte returned by RDSR; bit0 (WIP) is forced to 0.

Ports:
- clk  in  1  system clock; same clock as the shifter.
- reset  in  1  asynchronous, active-high.
- spi_cs  in  1  synchronised chip select, active low; high means the transaction has ended.
- spi_rx_strobe  in  1  one-cycle pulse; a received byte is valid.
- spi_rx_data  in  8  received byte.
- spi_tx_strobe  out  1  level; high while spi_tx_data holds the byte to shift out. When low, the shifter sends 0xFF.
- spi_tx_data  out  8  next byte to transmit.
- mem_rd_req  out  1  memory read request; held until ack.
- mem_addr  out  ADDR_W  read address.
- mem_rd_ack  in  1  one-cycle pulse; mem_rd_data is valid.
- mem_rd_data  in  8  read byte.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, address 0, prefetch-valid 0.
- spi_cs high, checked every cycle with priority over everything: next cycle the block goes to IDLE, drops spi_tx_strobe and mem_rd_req, and aborts any pending memory request (a late ack is ignored).
- States:
  - IDLE -> CMD when spi_cs is low.
  - CMD, on the first rx strobe:
    - 0x03 -> ADDR.
    - 0x9F -> ID.
    - 0x05 -> STAT.
    - 0x0B -> ADDR, only with the optional feature.
    - Anything else -> IGNORE.
  - ADDR: shifts in 3 bytes MSB first using a 2-bit counter. On the 3rd strobe, address = {b0,b1,b2}[ADDR_W-1:0].
    - For 0x03: issue a memory read of that address and go to DATA.
    - For 0x0B: go to DUMMY.
  - DUMMY: one rx strobe is discarded, then the memory read is issued and the block goes to DATA.
  - DATA:
    - On ack: load spi_tx_data, assert spi_tx_strobe, increment the address, and immediately request the next byte into a 1-byte prefetch register.
    - On each rx strobe: spi_tx_data <= prefetch and request the next byte.
    - If the prefetch is not valid at the rx strobe: spi_tx_strobe drops (0xFF goes out) and the late data is loaded on arrival. This is an underrun; it is counted by a sticky internal flag only.
  - ID:
    - On entry, tx = JEDEC_ID[23:16] with strobe high.
    - Each rx strobe advances to [15:8], then [7:0], then strobe drops.
  - STAT: tx = STATUS_VAL & 8'hFE, held for all subsequent bytes, so repeated RDSR polling works.
  - IGNORE: spi_tx_strobe low; rx strobes are ignored until spi_cs goes high.
- Timing: the first transmit byte must be loaded within 8 SPI half-periods after the command/address strobe. The memory port must ack within that budget; it is not checked.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFFFF wraps to 0x000000.
- An rx strobe in the same cycle as spi_cs rising is ignored.
- Write and erase opcodes (0x02, 0x20, 0x06 and others) go to IGNORE; the flash is read-only.

Optional Feature:
- Macro SPI_FLASH_FAST_READ_EN.
- Defined: 0x0B is decoded with a 3-byte address plus 1 dummy byte, then streams exactly like 0x03.
- Undefined: 0x0B goes to IGNORE; the DUMMY state and its logic are not built.

Decomposition:
- Package spi_flash_pkg:
  - Opcode constants: OP_READ, OP_FAST_READ, OP_RDID, OP_RDSR.
  - State enum type.
  - ADDR_BYTES = 3.
- One sub-module, spi_flash_prefetch: holds the request/ack handshake, prefetch register, valid flag and address increment.
- The top level holds the decode FSM and the tx mux.

Test Plan:
- RDID: cs low, send 9F 00 00 00 -> tx bytes FF(cmd slot), EF, 40, 18; after the 4th byte strobe goes low.
- READ at 0x000100, memory mem[a] = a[7:0], send 03 00 01 00 then 4 dummy bytes -> mem_addr sequence 100,101,102,103,104 and returned data 00,01,02,03.
- Wrap: READ at 0xFFFFFE, 3 data bytes -> addresses FFFFFE, FFFFFF, 000000.
- RDSR with STATUS_VAL=8'h03: send 05 00 00 -> tx 02, 02.
- Abort: raise spi_cs after the 2nd address byte, then send 9F -> clean RDID response, no mem_rd_req; a late ack arriving during the abort is ignored.
- Unsupported 0x02 with the macro off, then 0x0B -> both IGNORE with tx strobe low; with the macro on, 0x0B 00 00 10 + dummy -> data from 0x000010.
